// File: rtl/pixel_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_fifo
// Description : Display-side pixel FIFO with almost-full read request to the
//               loader and windowed, 1-cycle-latency pixel release.
//               Optional PIXEL_STREAM_STATS_EN adds a per-frame pop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PIPE_LAT   = 6,
    parameter int IMG_W      = 225,
    parameter int IMG_H      = 225,
    parameter int COORD_W    = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_vsync,
    input  logic                       i_valid,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_next,
    input  logic                       i_de,
    input  logic [COORD_W-1:0]         i_x,
    input  logic [COORD_W-1:0]         i_y,
    output logic                       o_de,
    output logic [DATA_WIDTH-1:0]      o_pixel,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_underflow,
    output logic                       o_overflow
`ifdef PIXEL_STREAM_STATS_EN
   ,output logic [15:0]                o_frame_pops
`endif
);

    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_LW      = c_AW + 1;
    localparam int c_NEXT_TH = DEPTH - PIPE_LAT;

    logic [c_AW:0]           r_wr_ptr;
    logic [c_AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [c_LW-1:0]         w_level;
    logic                    w_in_win;
    logic                    w_pop_req;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    // Extra pointer bit makes full/empty distinguishable through plain subtraction.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == c_LW'(DEPTH));

    assign w_in_win  = i_de && (i_x < COORD_W'(IMG_W)) && (i_y < COORD_W'(IMG_H));
    assign w_pop_req = w_in_win && i_vsync;
    assign w_pop     = w_pop_req && !w_empty;
    // A full FIFO still accepts when a real pop frees a slot in the same cycle.
    assign w_push    = i_valid && i_vsync && (!w_full || w_pop);
    assign w_drop    = i_valid && i_vsync && !w_push;

    assign o_next    = i_vsync && (w_level < c_LW'(c_NEXT_TH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            o_de        <= 1'b0;
            o_pixel     <= '0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_de <= i_de;
            if (!i_vsync) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                o_pixel  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    o_pixel  <= r_mem[r_rd_ptr[c_AW-1:0]];
                end else begin
                    o_pixel  <= '0;
                end
                if (w_pop_req && w_empty) begin
                    o_underflow <= 1'b1;
                end
                if (w_drop) begin
                    o_overflow <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
        end
    end

`ifdef PIXEL_STREAM_STATS_EN
    logic        r_vsync_d;
    logic [15:0] r_pop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d    <= 1'b0;
            r_pop_cnt    <= '0;
            o_frame_pops <= '0;
        end else begin
            r_vsync_d <= i_vsync;
            if (r_vsync_d && !i_vsync) begin
                o_frame_pops <= r_pop_cnt;
                r_pop_cnt    <= '0;
            end else if (w_pop) begin
                r_pop_cnt    <= r_pop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_fifo
// Description : Directed plus randomized bench for pixel_stream_fifo against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_fifo;

    localparam int c_DEPTH = 16;
    localparam int c_LAT   = 6;
    localparam int c_W     = 225;
    localparam int c_H     = 225;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_vsync;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_next;
    logic        i_de;
    logic [10:0] i_x;
    logic [10:0] i_y;
    logic        o_de;
    logic [7:0]  o_pixel;
    logic [4:0]  o_level;
    logic        o_underflow;
    logic        o_overflow;
`ifdef PIXEL_STREAM_STATS_EN
    logic [15:0] o_frame_pops;
`endif

    pixel_stream_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vsync     (i_vsync),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_next      (o_next),
        .i_de        (i_de),
        .i_x         (i_x),
        .i_y         (i_y),
        .o_de        (o_de),
        .o_pixel     (o_pixel),
        .o_level     (o_level),
        .o_underflow (o_underflow),
        .o_overflow  (o_overflow)
`ifdef PIXEL_STREAM_STATS_EN
       ,.o_frame_pops(o_frame_pops)
`endif
    );

    always #5 clk = ~clk;

    int          r_n_checks = 0;
    int          r_n_pass   = 0;

    // Reference model state
    logic [7:0]  m_q [$];
    logic [7:0]  m_pix;
    logic        m_de;
    logic        m_uf;
    logic        m_of;
    logic        m_prev_vs;
    int          m_pops;
    int          m_frame_pops;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_n_checks++;
        if (got === exp) begin
            r_n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pix        = '0;
        m_de         = 1'b0;
        m_uf         = 1'b0;
        m_of         = 1'b0;
        m_prev_vs    = 1'b0;
        m_pops       = 0;
        m_frame_pops = 0;
    endtask

    // One clock: drive at negedge, check o_next, update model at posedge, compare.
    task automatic cyc(input logic vs, input logic va, input logic [7:0] d,
                       input logic de, input logic [10:0] x, input logic [10:0] y);
        int   old;
        logic win;
        i_vsync = vs;
        i_valid = va;
        i_data  = d;
        i_de    = de;
        i_x     = x;
        i_y     = y;
        #1;
        check("next", o_next, vs && (m_q.size() + c_LAT < c_DEPTH));
        @(posedge clk);
        win = de && (x < c_W) && (y < c_H);
        old = m_q.size();
        m_pix = '0;
        if (!vs) begin
            m_q.delete();
        end else begin
            if (win) begin
                if (old > 0) begin
                    m_pix = m_q.pop_front();
                    m_pops++;
                end else begin
                    m_uf = 1'b1;
                end
            end
            if (va) begin
                if (old < c_DEPTH || (win && old > 0)) m_q.push_back(d);
                else m_of = 1'b1;
            end
        end
        if (m_prev_vs && !vs) begin
            m_frame_pops = m_pops;
            m_pops       = 0;
        end
        m_prev_vs = vs;
        m_de      = de;
        #1;
        check("level", o_level, m_q.size());
        check("pixel", o_pixel, m_pix);
        check("de", o_de, m_de);
        check("underflow", o_underflow, m_uf);
        check("overflow", o_overflow, m_of);
`ifdef PIXEL_STREAM_STATS_EN
        check("frame_pops", o_frame_pops, m_frame_pops);
`endif
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_vsync = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_de    = 1'b0;
        i_x     = '0;
        i_y     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_level", o_level, 0);
        check("rst_pixel", o_pixel, 0);
        check("rst_de", o_de, 0);
        check("rst_uf", o_underflow, 0);
        check("rst_of", o_overflow, 0);
        rst_n = 1'b1;

        // Idle after reset: request asserted, FIFO empty
        cyc(1, 0, 8'h00, 0, 0, 0);
        check("idle_next", o_next, 1);

        // Fill ten pixels; request drops once level reaches DEPTH-PIPE_LAT
        for (int i = 1; i <= 10; i++) cyc(1, 1, 8'(i), 0, 0, 0);
        check("fill10_level", o_level, 10);
        check("fill10_next", o_next, 0);

        // Drain them in-window: pixels come out in order one cycle later
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 8'h00, 1, 11'(i), 0);
            check("drain_pixel", o_pixel, 32'(i + 1));
        end
        check("drain_level", o_level, 0);
        check("drain_next", o_next, 1);

        // Out-of-window DE does not pop
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'(8'h20 + i), 0, 0, 0);
        cyc(1, 0, 8'h00, 1, 230, 5);
        check("oow_pixel", o_pixel, 0);
        check("oow_level", o_level, 3);
        check("oow_uf", o_underflow, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, 1, 11'(i), 224);

        // Pop on empty with simultaneous push: underflow, no bypass
        cyc(1, 1, 8'h55, 1, 0, 0);
        check("uf_pixel", o_pixel, 0);
        check("uf_flag", o_underflow, 1);
        check("uf_level", o_level, 1);
        cyc(1, 0, 8'h00, 1, 1, 0);
        check("uf_next_pop", o_pixel, 8'h55);

        // Overflow then frame flush
        for (int i = 0; i < 16; i++) cyc(1, 1, 8'(i), 0, 0, 0);
        cyc(1, 1, 8'hAA, 0, 0, 0);
        check("of_flag", o_overflow, 1);
        check("of_level", o_level, 16);
        cyc(1, 1, 8'hBB, 1, 0, 0);
        check("full_pushpop_level", o_level, 16);
        cyc(0, 1, 8'hCC, 1, 0, 0);
        check("flush_level", o_level, 0);
        check("flush_of", o_overflow, 1);
        check("flush_pixel", o_pixel, 0);

        // Async reset mid-stream clears sticky flags
        rst_n = 1'b0;
        #2;
        check("async_rst_of", o_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized phases with varying push/pop densities
        for (int ph = 0; ph < 12; ph++) begin
            int pv;
            int pd;
            pv = $urandom_range(10, 95);
            pd = $urandom_range(10, 95);
            for (int n = 0; n < 250; n++) begin
                logic vs;
                vs = ($urandom_range(0, 99) >= 2);
                cyc(vs, ($urandom_range(0, 99) < pv), 8'($urandom),
                    ($urandom_range(0, 99) < pd),
                    11'($urandom_range(0, 260)), 11'($urandom_range(0, 240)));
            end
        end

        $display("%0d/%0d checks passed", r_n_pass, r_n_checks);
        $finish;
    end

endmodule
`default_nettype wire
